// File: rtl/dilated_layer_sequencer.sv
// dilated_layer_sequencer
//   Sequences a stack of per-layer 4-tap activation buffers and one shared
//   convolution/MAC unit. Layer k advances once every 2^(k*DILATION_LOG2)
//   accepted samples. For every selected layer, in ascending order, the
//   layer's buffer is shifted, then the compute unit is started on it. The
//   sequencer then waits for the unit to finish. A completion handshake is
//   presented once all selected layers are done.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   sample_valid  new sample waiting at buffer 0's input
//   sample_ready  sample accepted this cycle when sample_valid is also high (IDLE only)
//   shift_en      one-hot single-cycle shift strobe, one bit per layer buffer
//   layer_sel     layer that currently owns the compute unit
//   layer_start   single-cycle pulse; compute unit begins layer layer_sel
//   layer_done    single-cycle pulse from the compute unit
//   out_valid     sample fully processed; held until out_ready
//   out_ready     downstream accepts completion
//   ran_mask      layers processed for the current sample
//   busy          sequencer is not idle
//   err_spurious  sticky flag: layer_done arrived while not waiting for it
module dilated_layer_sequencer #(
    parameter int NUM_LAYERS    = 4,
    parameter int DILATION_LOG2 = 2,
    parameter int LW            = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic [NUM_LAYERS-1:0] shift_en,
    output logic [LW-1:0]         layer_sel,
    output logic                  layer_start,
    input  logic                  layer_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_LAYERS-1:0] ran_mask,
    output logic                  busy,
    output logic                  err_spurious
);

    localparam int unsigned CW = DILATION_LOG2 * (NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        START,
        WAIT,
        OUT
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [NUM_LAYERS-1:0] mask_d;
    logic [LW-1:0]         sel_nxt;
    logic                  has_next;
    logic                  accept;

    assign accept = sample_valid & sample_ready;

    // Layer k runs when the low k*DILATION_LOG2 count bits are zero. Shifting
    // those bits to the top discards the rest; for k = 0 the shift clears
    // everything, so layer 0 always runs.
    always_comb begin
        mask_d = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            mask_d[k] = ((cnt << (CW - k * DILATION_LOG2)) == '0);
        end
    end

    // Lowest selected layer above the current one; scanned downwards so the
    // last hit wins.
    always_comb begin
        has_next = 1'b0;
        sel_nxt  = layer_sel;
        for (int unsigned k = NUM_LAYERS - 1; k > 0; k--) begin
            if (ran_mask[k] && (LW'(k) > layer_sel)) begin
                has_next = 1'b1;
                sel_nxt  = LW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b0;
        shift_en     = '0;
        layer_start  = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                sample_ready = 1'b1;
                busy         = 1'b0;
                if (sample_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en[layer_sel] = 1'b1;
                state_nxt           = START;
            end
            START: begin
                layer_start = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (layer_done) begin
                    state_nxt = has_next ? SHIFT : OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            ran_mask     <= '0;
            layer_sel    <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= cnt + CW'(1);
                ran_mask  <= mask_d;
                layer_sel <= '0;
            end
            if ((state == WAIT) && layer_done && has_next) begin
                layer_sel <= sel_nxt;
            end
            if (layer_done && (state != WAIT)) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dilated_layer_sequencer.sv
// Testbench for dilated_layer_sequencer (NUM_LAYERS=4, DILATION_LOG2=2).
// Expected ran_mask values are pushed when a sample is offered and popped
// when the sequencer raises out_valid; the bench also plays the compute unit.
module tb_dilated_layer_sequencer;

    localparam int NL   = 4;
    localparam int DL   = 2;
    localparam int LW   = $clog2(NL);
    localparam int CMOD = 1 << (DL * (NL - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [NL-1:0] shift_en;
    logic [LW-1:0] layer_sel;
    logic          layer_start;
    logic          layer_done = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NL-1:0] ran_mask;
    logic          busy;
    logic          err_spurious;

    int            tests = 0;
    int            fails = 0;
    int            cnt_m = 0;
    logic          err_m = 1'b0;
    logic [NL-1:0] exp_q[$];

    dilated_layer_sequencer #(
        .NUM_LAYERS   (NL),
        .DILATION_LOG2(DL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .shift_en    (shift_en),
        .layer_sel   (layer_sel),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ran_mask    (ran_mask),
        .busy        (busy),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NL-1:0] model_mask(input int c);
        logic [NL-1:0] m;
        for (int k = 0; k < NL; k++) begin
            m[k] = ((c % (1 << (k * DL))) == 0);
        end
        return m;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_shift_en"}, shift_en, 0);
        check({tag, "_layer_sel"}, layer_sel, 0);
        check({tag, "_layer_start"}, layer_start, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_ran_mask"}, ran_mask, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_spurious, 0);
    endtask

    // Called at a negedge. Offers one sample, answers each start with a done
    // pulse done_dly cycles later, holds out_ready low for hold cycles, and
    // optionally pulses layer_done alongside every layer_start (spur) or
    // asserts reset while waiting on layer abort_at.
    task automatic run_sample(input int done_dly, input int hold, input bit spur, input int abort_at);
        logic [NL-1:0] m;
        logic [NL-1:0] e;
        int            guard;
        m = model_mask(cnt_m);
        sample_valid = 1'b1;
        guard = 0;
        while (!sample_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", guard < 100, 1);
        if (guard >= 100) begin
            sample_valid = 1'b0;
            return;
        end
        exp_q.push_back(m);
        cnt_m = (cnt_m + 1) % CMOD;
        @(negedge clk);
        sample_valid = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if (m[k]) begin
                check("shift_en", shift_en, 1 << k);
                check("start_in_shift", layer_start, 0);
                check("busy", busy, 1);
                check("ready_busy", sample_ready, 0);
                @(negedge clk);
                check("layer_start", layer_start, 1);
                check("start_sel", layer_sel, k);
                check("shift_in_start", shift_en, 0);
                if (spur) begin
                    layer_done = 1'b1;
                    err_m = 1'b1;
                end
                @(negedge clk);
                layer_done = 1'b0;
                if (spur) check("err_spurious_set", err_spurious, 1);
                if (k == abort_at) begin
                    #2 rst = 1'b1;
                    #1;
                    check_all_zero("abort");
                    @(negedge clk);
                    rst = 1'b0;
                    exp_q.delete();
                    cnt_m = 0;
                    err_m = 1'b0;
                    check("abort_ready", sample_ready, 1);
                    return;
                end
                for (int w = 1; w < done_dly; w++) begin
                    check("wait_sel", layer_sel, k);
                    check("wait_shift", shift_en, 0);
                    check("wait_start", layer_start, 0);
                    check("wait_out_valid", out_valid, 0);
                    @(negedge clk);
                end
                layer_done = 1'b1;
                @(negedge clk);
                layer_done = 1'b0;
            end
        end
        check("out_valid", out_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("ran_mask", ran_mask, e);
        check("ready_in_out", sample_ready, 0);
        check("err_sticky", err_spurious, err_m);
        if (hold > 0) begin
            sample_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_out_valid", out_valid, 1);
                check("hold_ran_mask", ran_mask, e);
                check("hold_ready", sample_ready, 0);
                check("hold_shift", shift_en, 0);
            end
            sample_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_valid", out_valid, 0);
        check("idle_ready", sample_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_ready", sample_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        check("release_ready", sample_ready, 1);
        check("release_busy", busy, 0);

        // Sample 0: every layer, done two cycles after each start.
        run_sample(2, 0, 1'b0, -1);
        // Samples 1..63 back-to-back, done one cycle after start.
        for (int i = 1; i < 64; i++) run_sample(1, 0, 1'b0, -1);
        // Sample 64: counter has wrapped, all layers again.
        run_sample(1, 0, 1'b0, -1);

        // Downstream stall with a sample offered meanwhile; next sample is
        // accepted on the first IDLE cycle.
        run_sample(1, 5, 1'b0, -1);
        run_sample(1, 0, 1'b0, -1);

        // Spurious done in IDLE, then alongside each layer_start.
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        err_m = 1'b1;
        check("err_idle", err_spurious, 1);
        check("err_idle_busy", busy, 0);
        run_sample(3, 0, 1'b1, -1);
        check("err_stays", err_spurious, 1);

        // Clean reset so the next sample is count 0, then abort mid-WAIT on
        // layer 2 and confirm the count restarts.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt_m = 0;
        err_m = 1'b0;
        check("err_cleared", err_spurious, 0);
        run_sample(2, 0, 1'b0, 2);
        run_sample(1, 0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dilated_layer_sequencer.md
Name: dilated_layer_sequencer

Overview:
Controller for a stack of per-layer 4-tap left-shift activation buffers and one shared convolution/MAC unit in the cached dilated causal convolution pipeline. For each accepted input sample it decides which layers advance, given each layer's dilation. For each such layer, in ascending order, it strobes that layer's buffer shift and then hands the shared compute unit to the layer. When all selected layers have completed, it presents a completion handshake downstream.

Parameters:
NUM_LAYERS, 4, number of layers/buffers sequenced; must be >= 2.
DILATION_LOG2, 2, log2 of the dilation growth per layer; layer k advances once every 2^(k*DILATION_LOG2) samples.
LW, $clog2(NUM_LAYERS), width of layer index.

Ports:
clk  in  1  clock
rst  in  1  reset: asynchronous, active-high
sample_valid  in  1  new input sample available; the sample sits at buffer 0's input
sample_ready  out  1  sequencer can accept a sample; high only in IDLE
shift_en  out  NUM_LAYERS  one-hot, 1-cycle shift strobe to layer k's buffer
layer_sel  out  LW  layer currently owning the compute unit
layer_start  out  1  1-cycle pulse; compute unit begins layer layer_sel
layer_done  in  1  1-cycle pulse from compute unit; layer finished
out_valid  out  1  sample fully processed; held until accepted
out_ready  in  1  downstream accepts completion
ran_mask  out  NUM_LAYERS  layers processed for this sample; valid while out_valid
busy  out  1  high in any state other than IDLE
err_spurious  out  1  sticky: layer_done seen outside WAIT

Behaviour:
- Reset (async, any state, including mid-sequence): state=IDLE, sample counter=0. All outputs are 0 (shift_en, layer_sel, layer_start, out_valid, ran_mask, busy, err_spurious) except sample_ready=1 once in IDLE.
- Sample counter: CW = DILATION_LOG2*(NUM_LAYERS-1) bits. Increments modulo 2^CW on each accept (sample_valid & sample_ready). Wrap-around is silent.
- Mask: on accept, mask[k] = 1 iff the low k*DILATION_LOG2 bits of the pre-increment count are all zero. mask[0] is always 1. The mask is latched into ran_mask.
- States: IDLE, SHIFT, START, WAIT, OUT.
- IDLE: sample_ready=1. On accept: latch mask, layer_sel=0, go to SHIFT.
- SHIFT: shift_en[layer_sel]=1 for exactly one cycle, then go to START.
- START: layer_start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold layer_sel and wait for layer_done. On layer_done: if a higher set bit exists in the mask, set layer_sel to the lowest such bit and go to SHIFT; otherwise go to OUT.
- OUT: out_valid=1, ran_mask held stable. On out_ready, go to IDLE next cycle. If out_ready is high on OUT entry, OUT lasts one cycle.
- Latency: accept at cycle T gives shift_en[0] at T+1 and layer_start at T+2. layer_done at cycle W gives the next SHIFT (or OUT) at W+1. Minimum accept-to-out_valid for a single layer = 4 cycles (done at T+3 gives out_valid at T+4).
- Layers not selected by the mask get no shift and no start. Selected layers are never skipped, and order is strictly ascending.
- layer_done in IDLE/SHIFT/START/OUT (including the same cycle as layer_start) is ignored for sequencing and sets err_spurious. err_spurious clears only on rst.
- sample_valid while busy is not accepted (sample_ready=0). Upstream must hold the sample; no internal queueing.
- shift_en is at most one-hot at all times, and layer_start never coincides with a shift_en bit.

Test Plan:
- Reset release, NUM_LAYERS=4, DILATION_LOG2=2: sample 0 accepted -> ran_mask=4'b1111; shift_en/layer_start pairs for layers 0,1,2,3 in order; done returned 2 cycles after each start -> out_valid asserted; out_ready=1 -> IDLE, sample_ready=1.
- Samples 1..16 back-to-back, done 1 cycle after each start -> ran_mask 0001 for samples 1-3, 0011 at sample 4, 0111 at sample 16; shift_en pulses only for masked layers.
- 64 samples then sample 64 -> counter wraps to 0, ran_mask=1111 again.
- out_ready held low 5 cycles -> out_valid and ran_mask stable, sample_ready=0, sample_valid ignored; out_ready=1 -> next sample accepted the cycle after return to IDLE.
- layer_done pulsed in IDLE and in the same cycle as layer_start -> err_spurious=1 and stays 1; sequence still waits for a genuine WAIT-state done.
- rst asserted asynchronously during WAIT for layer 2 -> all outputs 0 immediately, sample_ready=1 after release; next sample sees count 0 (ran_mask=1111).
